// File: rtl/lzrw1_token_scheduler.sv
// lzrw1_token_scheduler
//   Sequences LZRW1 compression of one source string. For every source
//   position it issues a match lookup and waits for the matcher's answer.
//   It then picks a copy or a literal token and hands that token to the
//   compressed-values writer.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   start, srcLength    job request (sampled in IDLE) and source byte count
//   reqValid/reqReady   match-lookup request handshake, reqPos = position
//   rspValid            one-cycle matcher response carrying rspLen,
//                       rspOffset and rspByte
//   Done, controlBit,   writer interface: a token is stored on every
//   length, Offset,     cycle with Done=0
//   OneByte
//   busy, finished      job status (finished pulses once at job end)
//   overflow            sticky, output capacity exhausted
//   outBytes,           compressed bytes / tokens emitted in this job
//   tokenCount
module lzrw1_token_scheduler #(
    parameter int STRINGSIZE = 4096,
    parameter int MINMATCH   = 3,
    parameter int MAXMATCH   = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] srcLength,
    output logic        reqValid,
    input  logic        reqReady,
    output logic [11:0] reqPos,
    input  logic        rspValid,
    input  logic [4:0]  rspLen,
    input  logic [11:0] rspOffset,
    input  logic [7:0]  rspByte,
    output logic        Done,
    output logic        controlBit,
    output logic [3:0]  length,
    output logic [11:0] Offset,
    output logic [7:0]  OneByte,
    output logic        busy,
    output logic        finished,
    output logic        overflow,
    output logic [12:0] outBytes,
    output logic [12:0] tokenCount
);

    localparam logic [13:0] CAP    = 14'(STRINGSIZE);
    localparam logic [4:0]  MAXLEN = 5'(MAXMATCH);
    localparam logic [4:0]  MINLEN = 5'(MINMATCH);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, FINISH} state_t;

    state_t      state;
    logic [12:0] src_len;
    logic [12:0] pos;
    logic [4:0]  tok_len;
    logic        tok_copy;
    logic        tok_fits;
    logic        done_q;

    logic [12:0] remaining;
    logic [4:0]  capped_len;
    logic [4:0]  eff_len;
    logic        is_copy;
    logic        fits;
    logic [12:0] next_pos;

    // Token decision is made from the live response in WAIT and registered.
    // The writer outputs are therefore already valid during the EMIT cycle.
    always_comb begin
        remaining  = src_len - pos;
        capped_len = (rspLen > MAXLEN) ? MAXLEN : rspLen;
        eff_len    = ({8'd0, capped_len} > remaining) ? remaining[4:0] : capped_len;
        is_copy    = (eff_len >= MINLEN) && (rspOffset != 12'd0) &&
                     ({1'b0, rspOffset} <= pos);
        fits       = ({1'b0, outBytes} + (is_copy ? 14'd2 : 14'd1)) <= CAP;
        next_pos   = pos + (tok_copy ? {8'd0, tok_len} : 13'd1);
    end

    // Reset masks Done combinationally, so that no token reaches the writer
    // while reset is high, even when reset lands in an EMIT cycle.
    assign Done = done_q | reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            src_len    <= '0;
            pos        <= '0;
            tok_len    <= '0;
            tok_copy   <= 1'b0;
            tok_fits   <= 1'b0;
            done_q     <= 1'b1;
            controlBit <= 1'b0;
            length     <= '0;
            Offset     <= '0;
            OneByte    <= '0;
            reqValid   <= 1'b0;
            reqPos     <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            overflow   <= 1'b0;
            outBytes   <= '0;
            tokenCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_len    <= ({1'b0, srcLength} > CAP) ? CAP[12:0] : srcLength;
                        pos        <= '0;
                        outBytes   <= '0;
                        tokenCount <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        if (srcLength == 13'd0) begin
                            finished <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            reqValid <= 1'b1;
                            reqPos   <= '0;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (reqReady) begin
                        reqValid <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (rspValid) begin
                        tok_len  <= eff_len;
                        tok_copy <= is_copy;
                        tok_fits <= fits;
                        if (fits) begin
                            done_q     <= 1'b0;
                            controlBit <= is_copy;
                            length     <= is_copy ? 4'(eff_len - MINLEN) : 4'd0;
                            Offset     <= is_copy ? rspOffset : 12'd0;
                            OneByte    <= is_copy ? 8'd0 : rspByte;
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    done_q     <= 1'b1;
                    controlBit <= 1'b0;
                    length     <= '0;
                    Offset     <= '0;
                    OneByte    <= '0;
                    if (tok_fits) begin
                        pos        <= next_pos;
                        outBytes   <= outBytes + (tok_copy ? 13'd2 : 13'd1);
                        tokenCount <= tokenCount + 13'd1;
                        if (next_pos == src_len) begin
                            finished <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            reqValid <= 1'b1;
                            reqPos   <= next_pos[11:0];
                            state    <= REQ;
                        end
                    end else begin
                        overflow <= 1'b1;
                        finished <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    finished <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzrw1_token_scheduler.sv
module tb_lzrw1_token_scheduler;

    logic        clock = 1'b0;
    logic        reset, start, reqReady, rspValid, sel;
    logic [12:0] srcLength;
    logic [4:0]  rspLen;
    logic [11:0] rspOffset;
    logic [7:0]  rspByte;
    logic        start_d, start_s;

    logic        d_reqValid, d_Done, d_controlBit, d_busy, d_finished, d_overflow;
    logic [11:0] d_reqPos, d_Offset;
    logic [3:0]  d_length;
    logic [7:0]  d_OneByte;
    logic [12:0] d_outBytes, d_tokenCount;
    logic        s_reqValid, s_Done, s_controlBit, s_busy, s_finished, s_overflow;
    logic [11:0] s_reqPos, s_Offset;
    logic [3:0]  s_length;
    logic [7:0]  s_OneByte;
    logic [12:0] s_outBytes, s_tokenCount;
    logic        m_reqValid, m_Done, m_controlBit, m_busy, m_finished, m_overflow;
    logic [11:0] m_reqPos, m_Offset;
    logic [3:0]  m_length;
    logic [7:0]  m_OneByte;
    logic [12:0] m_outBytes, m_tokenCount;

    int n_checks = 0;
    int n_fail   = 0;
    int dl[8], dof[8], db[8];

    always #5 clock = ~clock;

    assign start_d = start & ~sel;
    assign start_s = start & sel;

    lzrw1_token_scheduler dut (
        .clock(clock), .reset(reset), .start(start_d), .srcLength(srcLength),
        .reqValid(d_reqValid), .reqReady(reqReady), .reqPos(d_reqPos),
        .rspValid(rspValid), .rspLen(rspLen), .rspOffset(rspOffset), .rspByte(rspByte),
        .Done(d_Done), .controlBit(d_controlBit), .length(d_length), .Offset(d_Offset),
        .OneByte(d_OneByte), .busy(d_busy), .finished(d_finished), .overflow(d_overflow),
        .outBytes(d_outBytes), .tokenCount(d_tokenCount)
    );

    lzrw1_token_scheduler #(.STRINGSIZE(4)) dut_small (
        .clock(clock), .reset(reset), .start(start_s), .srcLength(srcLength),
        .reqValid(s_reqValid), .reqReady(reqReady), .reqPos(s_reqPos),
        .rspValid(rspValid), .rspLen(rspLen), .rspOffset(rspOffset), .rspByte(rspByte),
        .Done(s_Done), .controlBit(s_controlBit), .length(s_length), .Offset(s_Offset),
        .OneByte(s_OneByte), .busy(s_busy), .finished(s_finished), .overflow(s_overflow),
        .outBytes(s_outBytes), .tokenCount(s_tokenCount)
    );

    always_comb begin
        m_reqValid   = sel ? s_reqValid   : d_reqValid;
        m_Done       = sel ? s_Done       : d_Done;
        m_controlBit = sel ? s_controlBit : d_controlBit;
        m_busy       = sel ? s_busy       : d_busy;
        m_finished   = sel ? s_finished   : d_finished;
        m_overflow   = sel ? s_overflow   : d_overflow;
        m_reqPos     = sel ? s_reqPos     : d_reqPos;
        m_Offset     = sel ? s_Offset     : d_Offset;
        m_length     = sel ? s_length     : d_length;
        m_OneByte    = sel ? s_OneByte    : d_OneByte;
        m_outBytes   = sel ? s_outBytes   : d_outBytes;
        m_tokenCount = sel ? s_tokenCount : d_tokenCount;
    end

    // One job, checked token by token against a model built from the
    // compression rules. Responses come from dl/dof/db when directed,
    // otherwise from $urandom.
    task automatic run_job(input int src, input bit directed);
        int ss, len, pos, outb, toks, k, e, rl, off, by, size, explen, expoff, expbyte;
        bit ovf, cp, fin;
        ss = sel ? 4 : 4096;
        len = (src > ss) ? ss : src;
        pos = 0; outb = 0; toks = 0; k = 0; ovf = 1'b0; fin = 1'b0;
        @(negedge clock);
        start = 1'b1; srcLength = 13'(src);
        @(negedge clock);
        start = 1'b0; srcLength = 13'($urandom_range(0, 8191));
        n_checks++;
        if (m_busy !== 1'b1) begin n_fail++; $display("FAIL job_busy: got %b want 1", m_busy); end
        while (!fin && k <= len + 1) begin
            n_checks++;
            if (m_reqValid !== 1'b1 || m_reqPos !== 12'(pos) || m_Done !== 1'b1) begin
                n_fail++;
                $display("FAIL req: reqValid=%b reqPos=%0d Done=%b want 1/%0d/1", m_reqValid, m_reqPos, m_Done, pos);
            end
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 1) begin
                    rspValid = 1'b1; rspLen = 5'($urandom_range(0, 31)); rspOffset = 12'd1; start = 1'b1;
                end
                @(negedge clock);
                rspValid = 1'b0; start = 1'b0;
                n_checks++;
                if (m_reqValid !== 1'b1 || m_reqPos !== 12'(pos) || m_Done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL req_hold: reqValid=%b reqPos=%0d Done=%b want 1/%0d/1", m_reqValid, m_reqPos, m_Done, pos);
                end
            end
            reqReady = 1'b1;
            @(negedge clock);
            reqReady = 1'b0;
            n_checks++;
            if (m_reqValid !== 1'b0 || m_Done !== 1'b1) begin
                n_fail++; $display("FAIL wait: reqValid=%b Done=%b want 0/1", m_reqValid, m_Done);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                n_checks++;
                if (m_Done !== 1'b1 || m_busy !== 1'b1) begin
                    n_fail++; $display("FAIL wait_hold: Done=%b busy=%b want 1/1", m_Done, m_busy);
                end
            end
            if (directed) begin
                rl = dl[k]; off = dof[k]; by = db[k];
            end else begin
                rl = $urandom_range(0, 31);
                off = $urandom_range(0, (pos + 2 > 4095) ? 4095 : pos + 2);
                by = $urandom_range(0, 255);
            end
            rspValid = 1'b1; rspLen = 5'(rl); rspOffset = 12'(off); rspByte = 8'(by);
            @(negedge clock);
            rspValid = 1'b0;
            e = rl;
            if (e > 18) e = 18;
            if (e > len - pos) e = len - pos;
            cp = (e >= 3) && (off >= 1) && (off <= pos);
            size = cp ? 2 : 1;
            n_checks++;
            if (outb + size > ss) begin
                ovf = 1'b1;
                if (m_Done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %b want 1", m_Done); end
            end else begin
                explen = cp ? e - 3 : 0; expoff = cp ? off : 0; expbyte = cp ? 0 : by;
                if (m_Done !== 1'b0 || m_controlBit !== cp || m_length !== 4'(explen) ||
                    m_Offset !== 12'(expoff) || m_OneByte !== 8'(expbyte)) begin
                    n_fail++;
                    $display("FAIL token@%0d: got D=%b c=%b l=%0d o=%0d b=%0d want 0/%b/%0d/%0d/%0d",
                             pos, m_Done, m_controlBit, m_length, m_Offset, m_OneByte, cp, explen, expoff, expbyte);
                end
                outb += size; toks++; pos += cp ? e : 1;
            end
            k++;
            @(negedge clock);
            if (ovf || pos == len) begin
                n_checks++;
                if (m_finished !== 1'b1 || m_busy !== 1'b1 || m_reqValid !== 1'b0 || m_Done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL finish: fin=%b busy=%b reqValid=%b Done=%b want 1/1/0/1", m_finished, m_busy, m_reqValid, m_Done);
                end
                @(negedge clock);
                n_checks++;
                if (m_finished !== 1'b0 || m_busy !== 1'b0 || m_outBytes !== 13'(outb) ||
                    m_tokenCount !== 13'(toks) || m_overflow !== ovf) begin
                    n_fail++;
                    $display("FAIL totals: fin=%b busy=%b outBytes=%0d tokens=%0d ovf=%b want 0/0/%0d/%0d/%b",
                             m_finished, m_busy, m_outBytes, m_tokenCount, m_overflow, outb, toks, ovf);
                end
                fin = 1'b1;
            end
        end
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL job_end: no finish after %0d tokens (len %0d)", k, len);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        sel = 1'b0;
        n_checks++;
        if (m_Done !== 1'b1 || m_reqValid !== 1'b0 || m_busy !== 1'b0 || m_finished !== 1'b0 ||
            m_overflow !== 1'b0 || m_controlBit !== 1'b0 || m_length !== 4'd0 || m_Offset !== 12'd0 ||
            m_OneByte !== 8'd0 || m_reqPos !== 12'd0 || m_outBytes !== 13'd0 || m_tokenCount !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values: D=%b rv=%b busy=%b fin=%b ovf=%b c=%b l=%0d o=%0d b=%0d rp=%0d ob=%0d tc=%0d want 1 then zeros",
                     m_Done, m_reqValid, m_busy, m_finished, m_overflow, m_controlBit, m_length, m_Offset,
                     m_OneByte, m_reqPos, m_outBytes, m_tokenCount);
        end
        n_checks++;
        if (s_Done !== 1'b1 || s_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_small: Done=%b busy=%b want 1/0", s_Done, s_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_literals;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin dl[i] = 0; dof[i] = 0; db[i] = 8'h11 * (i + 1); end
        run_job(4, 1'b1);
        n_checks++;
        if (m_outBytes !== 13'd4 || m_tokenCount !== 13'd4) begin
            n_fail++; $display("FAIL literals: outBytes=%0d tokens=%0d want 4/4", m_outBytes, m_tokenCount);
        end
    endtask

    task automatic test_copy_clamp;
        sel = 1'b0;
        dl[0] = 0;  dof[0] = 0; db[0] = 8'h41;
        dl[1] = 25; dof[1] = 1; db[1] = 8'h99;
        dl[2] = 0;  dof[2] = 0; db[2] = 8'h42;
        run_job(20, 1'b1);
        n_checks++;
        if (m_outBytes !== 13'd4 || m_tokenCount !== 13'd3) begin
            n_fail++; $display("FAIL copy_clamp: outBytes=%0d tokens=%0d want 4/3", m_outBytes, m_tokenCount);
        end
    endtask

    task automatic test_offset_beyond;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin dl[i] = 0; dof[i] = 0; db[i] = 8'h30 + i; end
        dl[2] = 5; dof[2] = 3;
        run_job(8, 1'b1);
        n_checks++;
        if (m_tokenCount !== 13'd8) begin
            n_fail++; $display("FAIL offset_beyond: tokens=%0d want 8", m_tokenCount);
        end
    endtask

    task automatic test_small_capacity;
        sel = 1'b1;
        run_job(10, 1'b0);
        for (int i = 0; i < 4; i++) begin dl[i] = (i == 1) ? 31 : 0; dof[i] = (i == 1) ? 1 : 0; db[i] = 8'hA0 + i; end
        run_job(4, 1'b1);
        run_job(3, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_zero_len;
        int busy_cycles, fin_pulses;
        bit bad;
        sel = 1'b0; busy_cycles = 0; fin_pulses = 0; bad = 1'b0;
        @(negedge clock);
        start = 1'b1; srcLength = 13'd0;
        @(negedge clock);
        start = 1'b0;
        repeat (4) begin
            if (m_busy === 1'b1) busy_cycles++;
            if (m_finished === 1'b1) fin_pulses++;
            if (m_reqValid !== 1'b0 || m_Done !== 1'b1) bad = 1'b1;
            @(negedge clock);
        end
        n_checks++;
        if (busy_cycles != 1 || fin_pulses != 1 || bad || m_outBytes !== 13'd0) begin
            n_fail++;
            $display("FAIL zero_len: busy=%0d fin=%0d bad=%b outBytes=%0d want 1/1/0/0", busy_cycles, fin_pulses, bad, m_outBytes);
        end
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        @(negedge clock);
        start = 1'b1; srcLength = 13'd5;
        @(negedge clock);
        start = 1'b0; reqReady = 1'b1;
        @(negedge clock);
        reqReady = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (m_Done !== 1'b1 || m_busy !== 1'b0 || m_reqValid !== 1'b0 || m_finished !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait: Done=%b busy=%b reqValid=%b fin=%b want 1/0/0/0", m_Done, m_busy, m_reqValid, m_finished);
        end
        rspValid = 1'b1; rspLen = 5'd0; rspByte = 8'h5A;
        @(negedge clock);
        rspValid = 1'b0;
        repeat (2) begin
            n_checks++;
            if (m_Done !== 1'b1 || m_busy !== 1'b0 || m_tokenCount !== 13'd0) begin
                n_fail++; $display("FAIL stale_rsp: Done=%b busy=%b tokens=%0d want 1/0/0", m_Done, m_busy, m_tokenCount);
            end
            @(negedge clock);
        end
        // reset landing in the EMIT cycle must mask the token immediately
        start = 1'b1; srcLength = 13'd3;
        @(negedge clock);
        start = 1'b0; reqReady = 1'b1;
        @(negedge clock);
        reqReady = 1'b0; rspValid = 1'b1; rspLen = 5'd0;
        @(negedge clock);
        rspValid = 1'b0; reset = 1'b1;
        #1;
        n_checks++;
        if (m_Done !== 1'b1) begin n_fail++; $display("FAIL reset_emit: Done=%b want 1", m_Done); end
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (m_busy !== 1'b0 || m_tokenCount !== 13'd0) begin
            n_fail++; $display("FAIL reset_emit_state: busy=%b tokens=%0d want 0/0", m_busy, m_tokenCount);
        end
        run_job(5, 1'b0);
    endtask

    task automatic test_random;
        sel = 1'b0;
        for (int j = 0; j < 10; j++) run_job($urandom_range(1, 40), 1'b0);
        run_job(5000, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; srcLength = '0; reqReady = 1'b0;
        rspValid = 1'b0; rspLen = '0; rspOffset = '0; rspByte = '0;
        test_reset;
        test_literals;
        test_copy_clamp;
        test_offset_beyond;
        test_zero_len;
        test_small_capacity;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
